gray_ptr_sync: RTL and testbench
================================

# gray_ptr_sync

Destination-domain receiver for a Gray-coded pointer produced by `binary_to_gray` in another clock domain. It synchronizes the pointer through a flop chain and converts it back to binary. It also reports each update with the modular step size and flags any illegal multi-bit Gray transition. Typical use is the read/write pointer crossing of an async FIFO.

## Interface
- `VEC_W`, 4, pointer width in bits (≥2)
- `SYNC_STAGES`, 2, synchronizer depth in flops (≥2)

- `clk`  in  1  destination-domain clock
- `reset_n`  in  1  asynchronous, active-low reset
- `gray_i`  in  VEC_W  Gray-coded pointer, asynchronous to `clk`
- `err_clr_i`  in  1  synchronous clear of `err_o`
- `bin_o`  out  VEC_W  registered binary value of the synchronized pointer
- `delta_o`  out  VEC_W  (new − previous) mod 2^VEC_W, updated only on `upd_o`
- `upd_o`  out  1  one-cycle pulse when the synchronized pointer changes
- `err_o`  out  1  sticky flag: consecutive synchronized samples differ in more than one bit

## Operation
- **Sync chain:** `SYNC_STAGES` flops sample `gray_i`. The last stage is `g_sync`, and `g_prev` holds the previous `g_sync`.
- **Gray-to-binary:** `b[VEC_W-1] = g[VEC_W-1]`; `b[i] = b[i+1] ^ g[i]`. Applied to `g_sync`.
- **Change detect:** `x = g_sync ^ g_prev`. When `x != 0`, on the next edge:
  - `bin_o` ← `bin(g_sync)`
  - `delta_o` ← `bin(g_sync) − bin_o`, truncated to VEC_W bits (wraps naturally)
  - `upd_o` ← 1
- **Idle:** when `x == 0`, `upd_o` ← 0 and `bin_o`/`delta_o` hold.
- **Error:** a multi-bit change is `(x & (x−1)) != 0`.
  - Checked only once `primed` = 1. `primed` is cleared by reset and set by the first update.
  - The first update after reset is never an error, so any non-zero `gray_i` at reset release is accepted.
- **Error set/clear:** `err_o` sets on the same edge as the offending `upd_o`. `err_clr_i` clears it on the next edge. If set and clear coincide, set wins.

## Timing
- **Reset:**
  - `reset_n` low clears all sync flops, `g_prev`, `primed`, `bin_o`, `delta_o`, `upd_o` and `err_o` to 0.
  - This is asynchronous and needs no clock edge.
  - Reset asserted mid-operation discards in-flight samples. No `upd_o` is produced for them.
- **Latency:** `gray_i` stable before edge k appears on `bin_o`/`upd_o` after edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 cycles (3 at default).
- **Throughput:** one update per clock is supported. Back-to-back changes give back-to-back `upd_o` pulses, each with its own `delta_o`.
- **Stable input:** a stable `gray_i` gives no `upd_o`.
- **Registered outputs:** all outputs are registered; no combinational path from any input.

## Structure
- **Package `gray_pkg`:**
  - `MIN_SYNC_STAGES = 2`
  - elaboration checks on `VEC_W`/`SYNC_STAGES`
  - shared `gray2bin`/`bin2gray` function definitions, so source and destination conversion are defined in one place
- **Sub-module `gray_to_binary #(VEC_W)`:** combinational. It is the exact inverse of `binary_to_gray` and sits between `g_sync` and the output registers. It is reused by future pointer-compare logic.
- **Top level:** the sync chain, `g_prev`, `primed`, and the output and error registers.

## Test plan
All scenarios use defaults: VEC_W=4, SYNC_STAGES=2.
- **Reset with non-zero input:** hold `reset_n`=0 with `gray_i`=4'b0110 → all outputs 0. Release; on the 3rd edge `upd_o`=1 for one cycle, `bin_o`=4, `delta_o`=4, `err_o`=0.
- **Full count with wrap:** walk `gray_i` through the Gray sequence 0000→0001→0011→…→1000→0000, one step every 4 clocks.
  - Each step: one `upd_o` pulse 3 edges after the change, `bin_o` = 1,2,…,15,0, `delta_o`=1 every time, `err_o`=0.
  - The wrap from 15 to 0 also gives `delta_o`=1.
- **Illegal jump, then clear:**
  - From `bin_o`=2 (gray 0011), drive gray 0101 → `upd_o`=1, `bin_o`=6, `delta_o`=4, `err_o`=1 on the same edge.
  - Hold `gray_i`; `err_o` stays 1 until `err_clr_i`=1 for one cycle, then 0 on the next edge.
- **Clear versus set collision:** pulse `err_clr_i` on the same edge as a new 2-bit change (gray 0101→0000) → `err_o` remains 1.
- **Backward step:** from `bin_o`=15 (gray 1000), drive gray 1001 (bin 14) → `delta_o`=15, `err_o`=0.
- **Mid-operation reset:** with `bin_o`=9 (gray 1101), pulse `reset_n` low between edges → `bin_o`/`delta_o`/`upd_o`/`err_o` read 0 before the next edge. After release with `gray_i`=1101, one `upd_o` appears 3 edges later: `bin_o`=9, `delta_o`=9, `err_o`=0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for Gray-coded pointer crossings: limits, parameter
// checks and the reference Gray/binary conversions used on both sides.
package gray_pkg;

  localparam int unsigned MIN_SYNC_STAGES = 2;
  localparam int unsigned MIN_VEC_W       = 2;
  // Widest pointer the shared conversion functions handle.
  localparam int unsigned MAX_VEC_W       = 32;

  // True when a pointer width / synchronizer depth pair is usable.
  function automatic bit params_ok(input int unsigned vec_w, input int unsigned sync_stages);
    return (vec_w >= MIN_VEC_W) && (vec_w <= MAX_VEC_W) && (sync_stages >= MIN_SYNC_STAGES);
  endfunction

  // Source-side encoding; narrower values are zero-extended, which leaves
  // the low bits of the result exact.
  function automatic logic [MAX_VEC_W-1:0] bin2gray(input logic [MAX_VEC_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Destination-side decoding: b[msb] = g[msb], b[i] = b[i+1] ^ g[i].
  function automatic logic [MAX_VEC_W-1:0] gray2bin(input logic [MAX_VEC_W-1:0] gray);
    logic [MAX_VEC_W-1:0] bin;
    bin[MAX_VEC_W-1] = gray[MAX_VEC_W-1];
    for (int i = MAX_VEC_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder; exact inverse of binary_to_gray.
// Each binary bit is the XOR of all Gray bits at and above its position.
module gray_to_binary
  import gray_pkg::*;
#(
  parameter int unsigned VEC_W = 4
) (
  input  logic [VEC_W-1:0] gray,
  output logic [VEC_W-1:0] bin
);

  if (VEC_W < MIN_VEC_W) begin : gen_width_err
    $error("gray_to_binary: VEC_W must be at least %0d", MIN_VEC_W);
  end

  // Prefix XOR from the MSB down, written per bit to avoid a self-referencing chain.
  for (genvar i = 0; i < VEC_W; i++) begin : gen_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/gray_ptr_sync.sv
// Destination-domain receiver for a Gray-coded pointer: synchronizes it,
// decodes it to binary, reports each update with its modular step and
// flags illegal multi-bit Gray transitions.
module gray_ptr_sync
  import gray_pkg::*;
#(
  parameter int unsigned VEC_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [VEC_W-1:0] gray_i,
  input  logic             err_clr_i,
  output logic [VEC_W-1:0] bin_o,
  output logic [VEC_W-1:0] delta_o,
  output logic             upd_o,
  output logic             err_o
);

  if (!params_ok(VEC_W, SYNC_STAGES)) begin : gen_param_err
    $error("gray_ptr_sync: need VEC_W in [%0d,%0d] and SYNC_STAGES >= %0d",
           MIN_VEC_W, MAX_VEC_W, MIN_SYNC_STAGES);
  end

  localparam logic [VEC_W-1:0] VecOne = VEC_W'(1);

  logic [VEC_W-1:0] sync_q [SYNC_STAGES];
  logic [VEC_W-1:0] g_sync;
  logic [VEC_W-1:0] g_prev_q;
  logic [VEC_W-1:0] g_diff;
  logic [VEC_W-1:0] bin_sync;
  logic             changed;
  logic             multi_bit;
  logic             primed_q;
  logic [VEC_W-1:0] bin_q;
  logic [VEC_W-1:0] delta_q;
  logic             upd_q;
  logic             err_q;

  // Metastability chain; the first stage is the only one sampling gray_i.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign g_sync = sync_q[SYNC_STAGES-1];

  gray_to_binary #(
    .VEC_W(VEC_W)
  ) u_gray_to_binary (
    .gray(g_sync),
    .bin (bin_sync)
  );

  // Bits that flipped since the previous synchronized sample; more than one
  // set bit means the source skipped a Gray step or the crossing was unsafe.
  always_comb begin
    g_diff    = g_sync ^ g_prev_q;
    changed   = |g_diff;
    multi_bit = |(g_diff & (g_diff - VecOne));
  end

  // Previous sample tracking and output registers, updated once per change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_prev_q <= '0;
      primed_q <= 1'b0;
      bin_q    <= '0;
      delta_q  <= '0;
      upd_q    <= 1'b0;
    end else begin
      g_prev_q <= g_sync;
      upd_q    <= changed;
      if (changed) begin
        primed_q <= 1'b1;
        bin_q    <= bin_sync;
        delta_q  <= bin_sync - bin_q;
      end
    end
  end

  // Sticky error; a new violation takes priority over a coincident clear.
  // The first update after reset is exempt since the reference point is arbitrary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (changed && primed_q && multi_bit) begin
      err_q <= 1'b1;
    end else if (err_clr_i) begin
      err_q <= 1'b0;
    end
  end

  assign bin_o   = bin_q;
  assign delta_o = delta_q;
  assign upd_o   = upd_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Scoreboard bench for gray_ptr_sync at default parameters.
module tb_gray_ptr_sync;

  localparam int unsigned VecW = 4;

  typedef struct {
    logic [VecW-1:0] bin;
    logic [VecW-1:0] delta;
    logic            err;
    int              due;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [VecW-1:0] gray_i = 4'b0110;
  logic            err_clr_i = 1'b0;
  logic [VecW-1:0] bin_o;
  logic [VecW-1:0] delta_o;
  logic            upd_o;
  logic            err_o;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  gray_ptr_sync #(
    .VEC_W      (VecW),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .gray_i   (gray_i),
    .err_clr_i(err_clr_i),
    .bin_o    (bin_o),
    .delta_o  (delta_o),
    .upd_o    (upd_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called just after a posedge: the new value is sampled on the next edge,
  // so its update lands three edges later.
  task automatic push_exp(input logic [VecW-1:0] bin, input logic [VecW-1:0] delta,
                          input logic err);
    exp_t e;
    e.bin   = bin;
    e.delta = delta;
    e.err   = err;
    e.due   = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic step(input logic [VecW-1:0] gray, input logic [VecW-1:0] bin,
                      input logic [VecW-1:0] delta, input logic err);
    gray_i = gray;
    push_exp(bin, delta, err);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_err();
    err_clr_i = 1'b1;
    @(posedge clk);
    #1;
    err_clr_i = 1'b0;
    check_eq("err_after_clear", {31'd0, err_o}, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_bin"},   {28'd0, bin_o},   32'd0);
    check_eq({tag, "_delta"}, {28'd0, delta_o}, 32'd0);
    check_eq({tag, "_upd"},   {31'd0, upd_o},   32'd0);
    check_eq({tag, "_err"},   {31'd0, err_o},   32'd0);
  endtask

  // Every upd_o pulse must match the oldest pending expectation, on time.
  always @(negedge clk) begin
    if (reset_n && upd_o) begin
      if (sb.size() == 0) begin
        check_eq("spurious_upd", {31'd0, upd_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("upd_cycle", cyc,               e.due);
        check_eq("bin",       {28'd0, bin_o},   {28'd0, e.bin});
        check_eq("delta",     {28'd0, delta_o}, {28'd0, e.delta});
        check_eq("err",       {31'd0, err_o},   {31'd0, e.err});
      end
    end
  end

  initial begin
    logic [VecW-1:0] g;

    // Reset held with a non-zero pointer on the input.
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_hold");
    reset_n = 1'b1;
    push_exp(4'd4, 4'd4, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Fresh start from pointer 0 for the full count.
    reset_n = 1'b0;
    gray_i  = 4'b0000;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Full Gray walk 1..15 then wrap to 0, each step +1.
    for (int i = 1; i <= 16; i++) begin
      logic [VecW-1:0] b;
      b = VecW'(i);
      g = b ^ (b >> 1);
      step(g, b, 4'd1, 1'b0);
    end

    // Up to bin 2, then an illegal 2-bit jump to gray 0101 (bin 6).
    step(4'b0001, 4'd1, 4'd1, 1'b0);
    step(4'b0011, 4'd2, 4'd1, 1'b0);
    step(4'b0101, 4'd6, 4'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq("err_sticky", {31'd0, err_o}, 32'd1);
      @(posedge clk);
      #1;
    end
    clear_err();

    // Clear coincides with a new 2-bit change: set wins.
    gray_i = 4'b0000;
    push_exp(4'd0, 4'd10, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    err_clr_i = 1'b1;
    @(posedge clk);
    #1;
    err_clr_i = 1'b0;
    check_eq("err_set_wins", {31'd0, err_o}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    clear_err();

    // Forward to 15, then a backward step to 14, then on to 9.
    step(4'b1000, 4'd15, 4'd15, 1'b0);
    step(4'b1001, 4'd14, 4'd15, 1'b0);
    step(4'b1101, 4'd9,  4'd11, 1'b0);
    check_eq("pre_reset_bin", {28'd0, bin_o}, 32'd9);

    // Asynchronous reset between edges, then resynchronize the held pointer.
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    #1;
    reset_n = 1'b1;
    push_exp(4'd9, 4'd9, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(posedge clk);
    end
    check_eq("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
